// File: rtl/spi_master.sv
// SPI master, mode 0, fixed 32-bit MSB-first transfers.
// A transfer runs SETUP -> (HIGH, LOW) x 31 -> HIGH -> HOLD -> IDLE.
// The cycle that leaves HOLD drives done=1, ss_n=1 and busy=0. A start seen
// in that same cycle is ignored, so back-to-back transfers are spaced by at
// least one idle cycle.
// sclk, ss_n and mosi come straight from flops so they cannot glitch.
//
// Handshake: start is a request that is only looked at while busy=0 and
// done=0. The cycle in which start is taken is the capture cycle for tx_data.
// From the next cycle busy=1 and further starts are dropped, not queued.
// done is a one-cycle completion strobe, and rx_data is valid with it.
// rx_data then holds its value until the next done.
module spi_master #(
  parameter int CLK_DIV  = 4,  // clock cycles per sclk half-period (4..255)
  parameter int CS_SETUP = 4,  // ss_n low to first sclk rise (1..255)
  parameter int CS_HOLD  = 4   // last sclk fall to ss_n rise (1..255)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_data,
  output logic        sclk,
  output logic        mosi,
  output logic        ss_n,
  input  logic        miso,
  output logic [2:0]  state      // FSM state, exposed for debug/checkers
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  // Terminal values for the phase counter in each timed state.
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  logic [7:0]  phase_cnt;
  logic [4:0]  bit_cnt;
  logic [7:0]  phase_limit;
  logic        phase_end;
  logic        accept;
  logic        last_bit;
  logic [31:0] tx_shift;
  logic [31:0] rx_shift;
  logic        miso_meta;
  logic        miso_sync;

  // Select how many cycles the current state lasts.
  always_comb begin
    phase_limit = 8'd0;
    case (state)
      ST_SETUP: phase_limit = SETUP_LAST;
      ST_HIGH:  phase_limit = DIV_LAST;
      ST_LOW:   phase_limit = DIV_LAST;
      ST_HOLD:  phase_limit = HOLD_LAST;
      default:  phase_limit = 8'd0;
    endcase
  end

  assign phase_end = (phase_cnt == phase_limit);
  assign last_bit  = (bit_cnt == 5'd31);
  // A start is not taken in the done cycle, although the FSM is already IDLE.
  assign accept    = (state == ST_IDLE) && start && !done;

  // Phase counter: counts cycles within SETUP/HIGH/LOW/HOLD and restarts at
  // every state change. It never exceeds phase_limit, so it cannot wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_cnt <= 8'd0;
    end else if (state == ST_IDLE || phase_end) begin
      phase_cnt <= 8'd0;
    end else begin
      phase_cnt <= phase_cnt + 8'd1;
    end
  end

  // Bit counter: index of the bit being clocked. It advances at the end of
  // each LOW phase and tops out at 31, because bit 31 has no LOW phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= 5'd0;
    end else if (state == ST_IDLE) begin
      bit_cnt <= 5'd0;
    end else if (state == ST_LOW && phase_end) begin
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // State register and next-state sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept)    state <= ST_SETUP;
        ST_SETUP: if (phase_end) state <= ST_HIGH;
        ST_HIGH:  if (phase_end) state <= last_bit ? ST_HOLD : ST_LOW;
        ST_LOW:   if (phase_end) state <= ST_HIGH;
        ST_HOLD:  if (phase_end) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Registered pin outputs and status flags.
  // They change together with the state that defines them.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk <= 1'b0;
      ss_n <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ss_n <= 1'b0;
            busy <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (phase_end) sclk <= 1'b1;
        end
        ST_HIGH: begin
          if (phase_end) sclk <= 1'b0;
        end
        ST_LOW: begin
          if (phase_end) sclk <= 1'b1;
        end
        ST_HOLD: begin
          if (phase_end) begin
            ss_n <= 1'b1;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: begin
          sclk <= 1'b0;
          ss_n <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end

  // Transmit path. The word is captured on acceptance and mosi starts at bit 31.
  // Each HIGH phase except the last ends by moving mosi to the next bit, so
  // mosi only changes on the first LOW cycle. The last value is held through
  // HOLD and cleared when the FSM returns to idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_shift <= 32'd0;
      mosi     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_shift <= tx_data;
            mosi     <= tx_data[31];
          end
        end
        ST_HIGH: begin
          if (phase_end && !last_bit) begin
            mosi     <= tx_shift[30];
            tx_shift <= {tx_shift[30:0], 1'b0};
          end
        end
        ST_HOLD: begin
          if (phase_end) mosi <= 1'b0;
        end
        default: begin
          mosi <= mosi;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous miso pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  // Receive path. A bit is sampled on the last cycle of every HIGH phase.
  // The slave had the whole preceding LOW phase to settle, plus the
  // synchronizer delay.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_shift <= 32'd0;
    end else if (state == ST_HIGH && phase_end) begin
      rx_shift <= {rx_shift[30:0], miso_sync};
    end
  end

  // Received word is published in the done cycle and held until the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data <= 32'd0;
    end else if (state == ST_HOLD && phase_end) begin
      rx_data <= rx_shift;
    end
  end

endmodule
